// File: rtl/dpram_pkg.sv
// Shared widths, depth and word/address types for the line-buffer dual-port RAM.
package dpram_pkg;

  localparam int unsigned DPRAM_ADDR_W = 9;
  localparam int unsigned DPRAM_DATA_W = 36;
  localparam int unsigned DPRAM_DEPTH  = 512;
  localparam int unsigned LINE_PIXELS  = 480;

  typedef logic [DPRAM_ADDR_W-1:0] dpram_addr_t;
  typedef logic [DPRAM_DATA_W-1:0] dpram_word_t;

endpackage

// File: rtl/dp_ram_if.sv
// Port bundle for dp_ram: write port A (fetch side) and read port B (scan-out side).
interface dp_ram_if
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W
);

  logic              a_wr;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_din;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_dout;

  modport master (
    output a_wr, a_addr, a_din, b_addr,
    input  b_dout
  );

  modport slave (
    input  a_wr, a_addr, a_din, b_addr,
    output b_dout
  );

endinterface

// File: rtl/dpram_array.sv
// Raw storage: one synchronous write port and one combinational read port.
module dpram_array
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W,
  parameter int unsigned DEPTH  = DPRAM_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dp_ram.sv
// Line-buffer dual-port RAM: range checks, reset write gating, optional output
// register selected by DPRAM_OUTREG_EN (undefined = combinational read).
module dp_ram
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_W = DPRAM_ADDR_W,
  parameter int unsigned DATA_W = DPRAM_DATA_W,
  parameter int unsigned DEPTH  = DPRAM_DEPTH
) (
  input  logic     a_clk,
  input  logic     b_clk,
  input  logic     rst_n,
  dp_ram_if.slave  bus
);

  // One bit wider than the address so DEPTH == 2**ADDR_W stays representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] raw;

  // b_clk shares the a_clk net; it is kept only so the port list stays symmetric.
  logic unused_b_clk;
  assign unused_b_clk = b_clk;

  assign wr_ok = rst_n && bus.a_wr && ({1'b0, bus.a_addr} < DEPTH_L);
  assign rd_ok = ({1'b0, bus.b_addr} < DEPTH_L);

  dpram_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (a_clk),
    .we    (wr_ok),
    .waddr (bus.a_addr),
    .wdata (bus.a_din),
    .raddr (bus.b_addr),
    .rdata (raw)
  );

`ifdef DPRAM_OUTREG_EN
  logic [DATA_W-1:0] dout_q;

  // raw still holds the pre-write word at the edge, giving read-before-write.
  always_ff @(posedge a_clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else begin
      dout_q <= rd_ok ? raw : '0;
    end
  end

  assign bus.b_dout = dout_q;
`else
  assign bus.b_dout = rd_ok ? raw : '0;
`endif

endmodule

// File: tb/tb_dp_ram.sv
// Scoreboard bench for dp_ram (DEPTH = 480); expectations follow DPRAM_OUTREG_EN.
module tb_dp_ram;
  import dpram_pkg::*;

  localparam int unsigned DEPTH = LINE_PIXELS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int errors = 0;
  int checks = 0;

  dpram_word_t model [DPRAM_DEPTH];
  dpram_word_t exp_q [$];

  dp_ram_if #(.ADDR_W(DPRAM_ADDR_W), .DATA_W(DPRAM_DATA_W)) bus ();

  dp_ram #(
    .ADDR_W (DPRAM_ADDR_W),
    .DATA_W (DPRAM_DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .a_clk (clk),
    .b_clk (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input int unsigned addr, input dpram_word_t data);
    bus.a_wr   = 1'b1;
    bus.a_addr = dpram_addr_t'(addr);
    bus.a_din  = data;
    if (addr < DEPTH) model[addr] = data;
    tick();
    bus.a_wr = 1'b0;
  endtask

  task automatic read_range(input string name);
    dpram_word_t got;
    dpram_word_t exp;
    for (int i = 0; i < int'(DEPTH); i++) begin
      exp_q.push_back(model[i]);
      bus.b_addr = dpram_addr_t'(i);
      tick();
      got = bus.b_dout;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s addr=%0d got=0x%09h expected=0x%09h", name, i, got, exp);
      end
    end
  endtask

  task automatic test_reset();
    bus.a_wr   = 1'b0;
    bus.a_addr = '0;
    bus.a_din  = '0;
    bus.b_addr = '0;
    rst_n      = 1'b0;
    repeat (3) tick();
`ifdef DPRAM_OUTREG_EN
    checks++;
    if (bus.b_dout !== '0) begin
      errors++;
      $display("FAIL reset_dout got=0x%09h expected=0x%09h", bus.b_dout, 36'h0);
    end
`endif
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 0; i < int'(DEPTH); i++) begin
      write_word(i, dpram_word_t'(i));
      tick();
    end
    read_range("fill");
  endtask

  task automatic test_collision();
    dpram_word_t exp_edge;
    write_word(5, 36'h1);
    bus.b_addr = dpram_addr_t'(5);
    tick();
    bus.a_wr   = 1'b1;
    bus.a_addr = dpram_addr_t'(5);
    bus.a_din  = 36'h2;
    #1;
    checks++;
    if (bus.b_dout !== 36'h1) begin
      errors++;
      $display("FAIL collision_before got=0x%09h expected=0x%09h", bus.b_dout, 36'h1);
    end
    tick();
    bus.a_wr  = 1'b0;
    model[5]  = 36'h2;
`ifdef DPRAM_OUTREG_EN
    exp_edge = 36'h1;
`else
    exp_edge = 36'h2;
`endif
    checks++;
    if (bus.b_dout !== exp_edge) begin
      errors++;
      $display("FAIL collision_edge got=0x%09h expected=0x%09h", bus.b_dout, exp_edge);
    end
    tick();
    checks++;
    if (bus.b_dout !== 36'h2) begin
      errors++;
      $display("FAIL collision_next got=0x%09h expected=0x%09h", bus.b_dout, 36'h2);
    end
  endtask

  task automatic test_reset_blocks_write();
    dpram_word_t exp_rst;
    bus.b_addr = dpram_addr_t'(10);
    tick();
    rst_n      = 1'b0;
    bus.a_wr   = 1'b1;
    bus.a_addr = dpram_addr_t'(10);
    bus.a_din  = 36'hABC;
    tick();
`ifdef DPRAM_OUTREG_EN
    exp_rst = '0;
`else
    exp_rst = 36'h00A;
`endif
    checks++;
    if (bus.b_dout !== exp_rst) begin
      errors++;
      $display("FAIL dout_in_reset got=0x%09h expected=0x%09h", bus.b_dout, exp_rst);
    end
    rst_n    = 1'b1;
    bus.a_wr = 1'b0;
    for (int i = 9; i <= 11; i++) begin
      dpram_word_t got;
      dpram_word_t exp;
      exp_q.push_back(model[i]);
      bus.b_addr = dpram_addr_t'(i);
      tick();
      got = bus.b_dout;
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_blocks_write addr=%0d got=0x%09h expected=0x%09h", i, got, exp);
      end
    end
  endtask

  task automatic test_out_of_range();
    write_word(511, 36'h123);
    bus.b_addr = dpram_addr_t'(3);
    tick();
    bus.b_addr = dpram_addr_t'(511);
    tick();
    checks++;
    if (bus.b_dout !== '0) begin
      errors++;
      $display("FAIL oor_read got=0x%09h expected=0x%09h", bus.b_dout, 36'h0);
    end
    read_range("oor_unchanged");
  endtask

  task automatic test_read_latency();
    dpram_word_t exp_now;
    bus.b_addr = dpram_addr_t'(100);
    tick();
    bus.b_addr = dpram_addr_t'(7);
    #1;
`ifdef DPRAM_OUTREG_EN
    exp_now = 36'd100;
`else
    exp_now = 36'd7;
`endif
    checks++;
    if (bus.b_dout !== exp_now) begin
      errors++;
      $display("FAIL latency_now got=0x%09h expected=0x%09h", bus.b_dout, exp_now);
    end
    tick();
    checks++;
    if (bus.b_dout !== 36'd7) begin
      errors++;
      $display("FAIL latency_next got=0x%09h expected=0x%09h", bus.b_dout, 36'd7);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_collision();
    test_reset_blocks_write();
    test_out_of_range();
    test_read_latency();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dp_ram.md
# dp_ram

Simple dual-port RAM used as the framebuffer line buffer (480 active entries of a 512-deep array). Port A is write-only, port B is read-only, and both run in one clock domain. Port A is written by the SDRAM fetch side; port B is read by the pixel/scan-out side, which needs a same-cycle (combinational) read.

## Interface
Parameters:
- `ADDR_W`, default 9: address width of both ports.
- `DATA_W`, default 36: word width.
- `DEPTH`, default 512: number of words. Must satisfy `DEPTH <= 2**ADDR_W`.

Ports:
- `a_clk`, input, 1: the single clock. One clock; all sequential logic is on its rising edge.
- `b_clk`, input, 1: must be tied to the same net as `a_clk`. It exists only for port symmetry and drives no independent logic.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `a_wr`, input, 1: write enable for port A.
- `a_addr`, input, `ADDR_W`: write address.
- `a_din`, input, `DATA_W`: write data.
- `b_addr`, input, `ADDR_W`: read address.
- `b_dout`, output, `DATA_W`: read data.

## Operation
- Write: on a rising edge with `rst_n`=1 and `a_wr`=1, `mem[a_addr] <= a_din`.
- Writes are ignored while `rst_n`=0.
- Writes with `a_addr >= DEPTH` are ignored.
- Read (default build): `b_dout = mem[b_addr]`, combinational.
- Reads with `b_addr >= DEPTH` return all zeros.
- Memory contents are not cleared by reset. Words never written are X in simulation and undefined in hardware.
- Same-address collision (combinational read): before the write edge `b_dout` shows the old word; after the edge it shows the new word.
- No other state. No handshake; every cycle is accepted.

## Timing
- Write latency: 1 edge. Data is visible on `b_dout` immediately after the write edge.
- Read latency (default build): 0 cycles. A `b_addr` driven at edge k is valid on `b_dout` before edge k+1.
- Reset: `b_dout` in the default build is not affected by reset; it always reflects the array.
- Reset taking effect mid-sequence blocks only the write on that edge. Earlier writes are retained.

## Configuration
- Macro: `DPRAM_OUTREG_EN`.
- Undefined (default): combinational read, 0-cycle latency, as described above.
- Defined: `b_dout` is registered, `b_dout <= mem[b_addr]` on each edge.
  - Read latency becomes 1 cycle.
  - The register resets to 0 while `rst_n`=0.
  - On a same-edge collision it returns the old word (read-before-write).
  - Out-of-range reads register 0.

## Structure
- Package `dpram_pkg`:
  - `DPRAM_ADDR_W`=9, `DPRAM_DATA_W`=36, `DPRAM_DEPTH`=512.
  - `LINE_PIXELS`=480.
  - Typedefs `dpram_addr_t` and `dpram_word_t`.
- One sub-module, `dpram_array`: the storage array with its write port and raw read. The top level adds the range checks, write gating by reset, and the optional output register.

## Test plan
- Fill and check, default build: write `mem[i] = {4'd0, i}` for i = 0..479 with `a_wr` pulsed once every other cycle. Then present `b_addr` = i and sample one edge later: `b_dout == {4'd0, i}` for every i, with no errors.
- Collision: with `mem[5]`=0x1, write 0x2 to address 5 while `b_addr`=5. Before the edge `b_dout`=0x1, after the edge 0x2. With `DPRAM_OUTREG_EN`, the register captures 0x1 on the write edge and 0x2 on the next edge.
- Reset blocks write: `rst_n`=0, `a_wr`=1, `a_addr`=10, `a_din`=0xABC. Afterwards `mem[10]` keeps its prior value (0x00A from the fill).
- Out of range: write 0x123 to `a_addr`=511 with `DEPTH`=480. Reading 511 returns 0, and addresses 0..479 are unchanged.
- Output register, `DPRAM_OUTREG_EN`: during reset `b_dout`=0. After reset, `b_addr`=7 at edge k gives `b_dout`=0x007 after edge k+1.
